// File: rtl/mul8_ha_pkg.sv
// Shared types and constants for the 8x8 HA-array final-addition stage.
// arr_value gives the weighted contribution of one row-pair array.
package mul8_ha_pkg;

  localparam int NUM_ARR = 4;
  localparam int B_W     = 7;
  localparam int T_W     = 9;
  localparam int OUT_W   = 16;
  localparam int SUM_W   = 17;

  typedef struct packed {
    logic [B_W-1:0] b;
    logic [T_W-1:0] t;
  } ha_arr_t;

  function automatic logic [SUM_W-1:0] arr_value(
    input int unsigned    k,
    input logic [B_W-1:0] b,
    input logic [T_W-1:0] t
  );
    logic [SUM_W-1:0] w_t;
    logic [SUM_W-1:0] w_b;
    w_t = SUM_W'(t);
    w_b = SUM_W'(b) << 2;
    return (w_t + w_b) << (2 * k);
  endfunction

endpackage

// File: rtl/unsigned_mul_8x8_ha_accum_if.sv
// Handshake and data bundle between the HA stage, the accumulator
// and its consumer.
interface unsigned_mul_8x8_ha_accum_if;
  import mul8_ha_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [B_W-1:0]   ha_array_0_b;
  logic [B_W-1:0]   ha_array_1_b;
  logic [B_W-1:0]   ha_array_2_b;
  logic [B_W-1:0]   ha_array_3_b;
  logic [T_W-1:0]   ha_array_0_t;
  logic [T_W-1:0]   ha_array_1_t;
  logic [T_W-1:0]   ha_array_2_t;
  logic [T_W-1:0]   ha_array_3_t;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;
  logic             ovf;

  modport master (
    output in_valid,
    output ha_array_0_b, ha_array_1_b,
    output ha_array_2_b, ha_array_3_b,
    output ha_array_0_t, ha_array_1_t,
    output ha_array_2_t, ha_array_3_t,
    output out_ready,
    input  in_ready, out_valid,
    input  product, ovf
  );

  modport slave (
    input  in_valid,
    input  ha_array_0_b, ha_array_1_b,
    input  ha_array_2_b, ha_array_3_b,
    input  ha_array_0_t, ha_array_1_t,
    input  ha_array_2_t, ha_array_3_t,
    input  out_ready,
    output in_ready, out_valid,
    output product, ovf
  );

endinterface

// File: rtl/mul8_ha_pipe_reg.sv
// One valid/ready register slice; data loads only with a valid beat.
// Ready toward upstream is combinational on downstream ready only.
module mul8_ha_pipe_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_adv;

  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // advance the slice whenever it is empty or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/unsigned_mul_8x8_ha_accum.sv
// Reduces four HA row-pair arrays to a 16-bit product plus overflow.
// Stage 1 forms two pair sums, stage 2 the final 17-bit sum.
module unsigned_mul_8x8_ha_accum
  import mul8_ha_pkg::*;
#(
  parameter int NUM_ARR = mul8_ha_pkg::NUM_ARR
) (
  input logic                         clk,
  input logic                         rst_n,
  unsigned_mul_8x8_ha_accum_if.slave  bus
);

  if (NUM_ARR != 4) begin : g_bad_num_arr
    $error("unsigned_mul_8x8_ha_accum: NUM_ARR must be 4");
  end

  ha_arr_t          w_arr [4];
  logic [SUM_W-1:0] w_v   [4];
  logic [SUM_W-1:0] w_p01;
  logic [SUM_W-1:0] w_p23;
  logic [2*SUM_W-1:0] w_s1_data;
  logic             w_s1_valid;
  logic             w_s2_ready;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_s2_data;

  assign w_arr[0] = {bus.ha_array_0_b, bus.ha_array_0_t};
  assign w_arr[1] = {bus.ha_array_1_b, bus.ha_array_1_t};
  assign w_arr[2] = {bus.ha_array_2_b, bus.ha_array_2_t};
  assign w_arr[3] = {bus.ha_array_3_b, bus.ha_array_3_t};

  for (genvar k = 0; k < 4; k++) begin : g_val
    assign w_v[k] = arr_value(k, w_arr[k].b, w_arr[k].t);
  end

  assign w_p01 = w_v[0] + w_v[1];
  assign w_p23 = w_v[2] + w_v[3];

  mul8_ha_pipe_reg #(.W(2*SUM_W)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  ({w_p23, w_p01}),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  assign w_sum = w_s1_data[SUM_W-1:0]
               + w_s1_data[2*SUM_W-1:SUM_W];

  mul8_ha_pipe_reg #(.W(SUM_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_sum),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2_data)
  );

  assign bus.product = w_s2_data[OUT_W-1:0];
  assign bus.ovf     = w_s2_data[SUM_W-1];

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_accum.sv
// Self-checking bench for unsigned_mul_8x8_ha_accum.
// Reference: weighted sum of the arrays and plain x*y.
module tb_unsigned_mul_8x8_ha_accum;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_accum_if bus ();

  unsigned_mul_8x8_ha_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef logic [3:0][6:0] barr_t;
  typedef logic [3:0][8:0] tarr_t;

  function automatic int ref_sum(barr_t b, tarr_t t);
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += (int'(t[k]) + 4 * int'(b[k])) * (1 << (2 * k));
    return s;
  endfunction

  // exact half-adder row-pair stage: rows 2k and 2k+1 of x*y
  task automatic ha_rows(input logic [7:0] x, input logic [7:0] y,
                         output barr_t b, output tarr_t t);
    logic [7:0] a, c;
    b = '0;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      a = y[2*k]   ? x : 8'h00;
      c = y[2*k+1] ? x : 8'h00;
      t[k][0] = a[0];
      for (int i = 1; i < 8; i++) begin
        t[k][i]   = a[i] ^ c[i-1];
        b[k][i-1] = a[i] & c[i-1];
      end
      t[k][8] = c[7];
    end
  endtask

  task automatic drive(input barr_t b, input tarr_t t);
    bus.ha_array_0_b = b[0];
    bus.ha_array_1_b = b[1];
    bus.ha_array_2_b = b[2];
    bus.ha_array_3_b = b[3];
    bus.ha_array_0_t = t[0];
    bus.ha_array_1_t = t[1];
    bus.ha_array_2_t = t[2];
    bus.ha_array_3_t = t[3];
  endtask

  task automatic rand_arr(output barr_t b, output tarr_t t);
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'($urandom);
      t[k] = 9'($urandom);
    end
  endtask

  // one beat with out_ready=1; returns output and latency (-1 on timeout)
  task automatic send_one(input barr_t b, input tarr_t t,
                          output logic [15:0] p, output logic o,
                          output int lat);
    int w;
    @(negedge clk);
    drive(b, t);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    lat = -1;
    p   = 16'h0;
    o   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      drive('0, '0);
      #1;
      if (bus.out_valid) begin
        lat = c;
        p   = bus.product;
        o   = bus.ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, '0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.product !== 16'h0
        || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b p=%h ovf=%b want 0/0000/0",
               bus.out_valid, bus.product, bus.ovf);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    barr_t b = '0;
    tarr_t t = '0;
    logic [15:0] p;
    logic o;
    int lat;
    t[0][0] = 1'b1;
    send_one(b, t, p, o, lat);
    n_tests++;
    if (p !== 16'h0001 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_bit: got %h/%b want 0001/0", p, o);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want 2", lat);
    end
  endtask

  task automatic test_corners();
    barr_t b;
    tarr_t t;
    logic [15:0] p;
    logic o;
    int lat;
    b = '0; t = '0; b[3][6] = 1'b1;
    send_one(b, t, p, o, lat);
    n_tests++;
    if (p !== 16'h4000 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL b3_msb: got %h/%b want 4000/0", p, o);
    end
    b = '0; t = '0; b[1][0] = 1'b1;
    send_one(b, t, p, o, lat);
    n_tests++;
    if (p !== 16'h0010 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL b1_lsb: got %h/%b want 0010/0", p, o);
    end
    b = '1; t = '1;
    send_one(b, t, p, o, lat);
    n_tests++;
    if (p !== 16'h5257 || o !== 1'b1) begin
      n_fail++;
      $display("FAIL all_ones: got %h/%b want 5257/1", p, o);
    end
  endtask

  task automatic test_random_arrays();
    barr_t b;
    tarr_t t;
    logic [15:0] p;
    logic o;
    int lat, s;
    for (int i = 0; i < 40; i++) begin
      rand_arr(b, t);
      s = ref_sum(b, t);
      send_one(b, t, p, o, lat);
      n_tests++;
      if (p !== 16'(s) || o !== (s >= 65536) || lat !== 2) begin
        n_fail++;
        $display("FAIL rand_arr[%0d]: got %h/%b lat %0d want %h/%b lat 2",
                 i, p, o, lat, 16'(s), (s >= 65536));
      end
    end
  endtask

  task automatic test_exact_mult();
    barr_t b;
    tarr_t t;
    logic [15:0] p;
    logic o;
    logic [7:0] x, y;
    int lat, e, n;
    longint sum_abs = 0, sum_sq = 0;
    ha_rows(8'hFF, 8'hFF, b, t);
    send_one(b, t, p, o, lat);
    n_tests++;
    if (p !== 16'hFE01 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_ff_ff: got %h/%b want FE01/0", p, o);
    end
    n = 300;
    for (int i = 0; i < n; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      ha_rows(x, y, b, t);
      send_one(b, t, p, o, lat);
      e = int'(p) + (o ? 65536 : 0) - int'(x) * int'(y);
      sum_abs += (e < 0) ? -e : e;
      sum_sq  += e * e;
      n_tests++;
      if (p !== 16'(int'(x) * int'(y)) || o !== 1'b0) begin
        n_fail++;
        $display("FAIL mult %h*%h: got %h/%b want %h/0",
                 x, y, p, o, 16'(int'(x) * int'(y)));
      end
    end
    n_tests++;
    if (sum_abs > 2 * n || sum_sq > 8 * n) begin
      n_fail++;
      $display("FAIL mult_err_stats: abs %0d sq %0d limit %0d/%0d",
               sum_abs, sum_sq, 2 * n, 8 * n);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int sent = 0, recvd = 0, cyc = 0, s;
    logic [2:0] pat = 3'b001;
    logic prev_stall = 1'b0;
    logic [15:0] prev_p = '0;
    logic prev_o = 1'b0;
    logic exp_rdy;
    barr_t b;
    tarr_t t;
    rand_arr(b, t);
    while (recvd < 10 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = pat[cyc % 3];
      bus.in_valid  = (sent < 10);
      drive(b, t);
      #1;
      exp_rdy = !(exp_q.size() == 2 && !bus.out_ready);
      n_tests++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_in_ready c%0d: got %b want %b",
                 cyc, bus.in_ready, exp_rdy);
      end
      if (prev_stall) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.product !== prev_p
            || bus.ovf !== prev_o) begin
          n_fail++;
          $display("FAIL b2b_hold c%0d: got %b/%h/%b want 1/%h/%b",
                   cyc, bus.out_valid, bus.product, bus.ovf,
                   prev_p, prev_o);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_p     = bus.product;
      prev_o     = bus.ovf;
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_dup c%0d: got %h want none", cyc, bus.product);
        end else begin
          s = exp_q.pop_front();
          if (bus.product !== 16'(s) || bus.ovf !== (s >= 65536)) begin
            n_fail++;
            $display("FAIL b2b_data #%0d: got %h/%b want %h/%b", recvd,
                     bus.product, bus.ovf, 16'(s), (s >= 65536));
          end
        end
        recvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_sum(b, t));
        sent++;
        rand_arr(b, t);
      end
      cyc++;
    end
    n_tests++;
    if (recvd != 10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d left %0d want 10 left 0",
               recvd, exp_q.size());
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    barr_t b;
    tarr_t t;
    logic [15:0] p;
    logic o;
    int lat, s;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    rand_arr(b, t);
    drive(b, t);
    @(negedge clk);
    rand_arr(b, t);
    drive(b, t);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_full: ov=%b ir=%b want 1/0",
               bus.out_valid, bus.in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.product !== 16'h0
        || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ov=%b p=%h ovf=%b want 0/0000/0",
               bus.out_valid, bus.product, bus.ovf);
    end
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_stale: ov=%b want 0", bus.out_valid);
    end
    rand_arr(b, t);
    s = ref_sum(b, t);
    send_one(b, t, p, o, lat);
    n_tests++;
    if (p !== 16'(s) || o !== (s >= 65536) || lat !== 2) begin
      n_fail++;
      $display("FAIL mid_after: got %h/%b lat %0d want %h/%b lat 2",
               p, o, lat, 16'(s), (s >= 65536));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_random_arrays();
    test_exact_mult();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
